sum_accum: RTL and testbench
============================

# sum_accum

Downstream consumer of the 32-bit combinational adder's `z` output. It accepts one adder result per cycle over a valid/ready handshake and accumulates a programmable-length block of results into a guard-extended sum. It presents the block total, sample count and a wide-result flag to the next stage over a second valid/ready handshake. Block length is programmable, and a partial block can be forced out with a flush.

## Interface
- `WIDTH`, default 32: width of each input sample (adder result).
- `CNT_W`, default 4: block-length field width; maximum block is 2^CNT_W samples.
- `GUARD`, default 8: extra accumulator bits above WIDTH. Must be ≥ CNT_W so the sum never wraps.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  WIDTH  sample (adder `z`).
- `len`  in  CNT_W  samples per block; 0 means 2^CNT_W. Sampled only on the first accept of a block.
- `flush`  in  1  single-cycle request to emit the current partial block.
- `out_valid`  out  1  block result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_sum`  out  WIDTH+GUARD  unsigned block total.
- `out_count`  out  CNT_W+1  number of samples in the block (1..2^CNT_W).
- `out_wide`  out  1  high when out_sum ≥ 2^WIDTH, i.e. any guard bit set.

## Operation
- Two-state FSM, ACCUM and HOLD. Reset enters ACCUM.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - Accept when in_valid=1. On accept: acc ← acc + zero-extended in_data, cnt ← cnt+1.
  - On the accept with cnt==0, the len register is loaded from `len`; len=0 maps to 2^CNT_W.
  - Move to HOLD when the accepted sample makes cnt+1 == the latched length.
  - Also move to HOLD when flush=1 and the post-update count is ≥1.
- HOLD:
  - in_ready=0 and out_valid=1. out_sum, out_count and out_wide stay stable; in_data and in_valid are ignored.
  - On out_ready=1: acc←0, cnt←0, return to ACCUM.
  - flush is ignored in HOLD.
- Flush cases in ACCUM:
  - flush together with an accepted sample: the sample is included, then the block is emitted.
  - flush with cnt==0 and no accept: ignored, state unchanged.
- Arithmetic:
  - Unsigned, full WIDTH+GUARD width, no saturation and no wrap (guaranteed by GUARD ≥ CNT_W).
  - out_wide = |out_sum[WIDTH+GUARD-1:WIDTH].
- A new `len` value mid-block has no effect until the next block's first accept.

## Timing
- Reset values: state=ACCUM, acc=0, cnt=0, len register = 2^CNT_W, out_valid=0, in_ready=1, out_sum=0, out_count=0, out_wide=0.
- Outputs are registered. in_ready and out_valid decode directly from the state register; there is no combinational path from in_valid or out_ready to any output.
- Latency: out_valid rises the cycle after the last sample is accepted (or after the flush cycle).
- Throughput: an N-sample block takes N accept cycles plus ≥1 HOLD cycle. With out_ready held high, HOLD lasts exactly 1 cycle and the next sample is accepted on the following cycle.
- Result handshake completes on a cycle with out_valid=1 and out_ready=1. out_valid falls the next cycle.
- Reset mid-block or in HOLD discards the partial block and the pending result; no output is produced.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_sum=0, out_count=0; nothing accepted.
- Basic block: len=4, out_ready=1, samples 1,2,3,4 back-to-back -> one cycle after the 4th accept: out_valid=1, out_sum=10, out_count=4, out_wide=0. in_ready=0 for exactly that one cycle.
- Wide result: len=2, samples 0xFFFFFFFF, 0x00000001 -> out_sum=0x0100000000, out_count=2, out_wide=1.
- Backpressure: complete a len=1 block with sample 0x55, hold out_ready=0 for 5 cycles while toggling in_data/in_valid -> out_valid and out_sum=0x55 stay stable, in_ready=0, no samples absorbed. Raise out_ready -> out_valid drops the next cycle.
- Flush:
  - len=8, samples 5,6,7, flush on the 7 cycle -> out_sum=18, out_count=3.
  - A later flush with cnt==0 and in_valid=0 -> no output.
- Max length and mid-block reset: len=0 with 16 samples of 0x10 -> out_sum=0x100, out_count=16. In a separate run, reset after 2 of 4 samples, then feed 4 samples of 1 -> out_sum=4, out_count=4.

Source files
------------

// File: rtl/sum_accum.sv
// Block accumulator for adder results: sums a programmable-length run of samples into a
// guard-extended total and hands the total, sample count and wide flag downstream.
module sum_accum #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 4,
   parameter int GUARD = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [CNT_W-1:0]       len,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH+GUARD-1:0] out_sum,
   output logic [CNT_W:0]         out_count,
   output logic                   out_wide
);

   localparam int ACC_W = WIDTH + GUARD;
   localparam logic [CNT_W:0] LEN_MAX = (CNT_W+1)'(1) << CNT_W;

   typedef enum logic {S_ACCUM = 1'b0, S_HOLD = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W:0]   r_cnt;
   logic [CNT_W:0]   r_len;
   logic [CNT_W:0]   w_len_eff;
   logic [CNT_W:0]   w_cnt_inc;
   logic             w_accept;
   logic             w_release;

   // A programmed length of zero stands for the full 2^CNT_W block.
   function automatic logic [CNT_W:0] decode_len(input logic [CNT_W-1:0] l);
      return (l == '0) ? LEN_MAX : {1'b0, l};
   endfunction

   assign w_accept  = (r_state == S_ACCUM) && in_valid;
   assign w_release = (r_state == S_HOLD) && out_ready;
   assign w_cnt_inc = r_cnt + (CNT_W+1)'(1);
   assign w_len_eff = (r_cnt == '0) ? decode_len(len) : r_len;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_ACCUM;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_ACCUM: begin
            if (w_accept && (w_cnt_inc == w_len_eff))
               w_state_nxt = S_HOLD;
            else if (flush && (w_accept || (r_cnt != '0)))
               w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) w_state_nxt = S_ACCUM;
         end
         default: w_state_nxt = S_ACCUM;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_ACCUM: in_ready  = 1'b1;
         S_HOLD:  out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // The length is latched only on the first accept, so mid-block len changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_len <= LEN_MAX;
      end else if (w_release) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= r_acc + {{GUARD{1'b0}}, in_data};
         r_cnt <= w_cnt_inc;
         if (r_cnt == '0) r_len <= decode_len(len);
      end
   end

   assign out_sum   = r_acc;
   assign out_count = r_cnt;
   assign out_wide  = |r_acc[ACC_W-1:WIDTH];

endmodule

// File: tb/tb_sum_accum.sv
// Table-driven bench for sum_accum with a result scoreboard and hand-written corner sequences.
module tb_sum_accum;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [3:0]  len;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [39:0] out_sum;
   logic [4:0]  out_count;
   logic        out_wide;

   sum_accum #(.WIDTH(32), .CNT_W(4), .GUARD(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .len       (len),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_wide  (out_wide)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [39:0] sum;
      logic [4:0]  cnt;
      logic        wide;
   } exp_t;

   typedef struct {
      logic [3:0]        len;
      int                n;
      logic [15:0][31:0] s;
      logic              flush_last;
      logic [39:0]       esum;
      logic [4:0]        ecnt;
      logic              ewide;
   } vec_t;

   vec_t vecs[6];
   exp_t q[$];
   exp_t m_e;
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every completed result handshake is checked against the oldest pushed expectation.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_out: got sum %0h count %0d, expected no output", out_sum, out_count);
         end else begin
            m_e = q.pop_front();
            chk("out_sum", 64'(out_sum), 64'(m_e.sum));
            chk("out_count", 64'(out_count), 64'(m_e.cnt));
            chk("out_wide", 64'(out_wide), 64'(m_e.wide));
         end
      end
   end

   task automatic wait_ready();
      int b = 0;
      while (in_ready !== 1'b1 && b < 20) begin
         tick();
         b++;
      end
      chk("in_ready_wait", 64'(in_ready), 64'(1));
   endtask

   task automatic run_block(input int k);
      vec_t v;
      exp_t e;
      v = vecs[k];
      e.sum  = v.esum;
      e.cnt  = v.ecnt;
      e.wide = v.ewide;
      q.push_back(e);
      out_ready = 1'b1;
      for (int i = 0; i < v.n; i++) begin
         wait_ready();
         in_valid = 1'b1;
         in_data  = v.s[i];
         len      = (i == 0) ? v.len : v.len + 4'd1;
         flush    = v.flush_last && (i == v.n - 1);
         tick();
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      in_data  = '0;
      chk($sformatf("blk%0d_out_valid_hold", k), 64'(out_valid), 64'(1));
      chk($sformatf("blk%0d_in_ready_hold", k), 64'(in_ready), 64'(0));
      tick();
      chk($sformatf("blk%0d_out_valid_after", k), 64'(out_valid), 64'(0));
      chk($sformatf("blk%0d_in_ready_after", k), 64'(in_ready), 64'(1));
   endtask

   initial begin
      vecs[0] = '{len: 4'd4, n: 4, s: '0, flush_last: 1'b0, esum: 40'd10, ecnt: 5'd4, ewide: 1'b0};
      vecs[0].s[0] = 32'd1; vecs[0].s[1] = 32'd2; vecs[0].s[2] = 32'd3; vecs[0].s[3] = 32'd4;
      vecs[1] = '{len: 4'd2, n: 2, s: '0, flush_last: 1'b0, esum: 40'h01_0000_0000, ecnt: 5'd2, ewide: 1'b1};
      vecs[1].s[0] = 32'hFFFF_FFFF; vecs[1].s[1] = 32'h0000_0001;
      vecs[2] = '{len: 4'd8, n: 3, s: '0, flush_last: 1'b1, esum: 40'd18, ecnt: 5'd3, ewide: 1'b0};
      vecs[2].s[0] = 32'd5; vecs[2].s[1] = 32'd6; vecs[2].s[2] = 32'd7;
      vecs[3] = '{len: 4'd0, n: 16, s: '0, flush_last: 1'b0, esum: 40'h100, ecnt: 5'd16, ewide: 1'b0};
      for (int i = 0; i < 16; i++) vecs[3].s[i] = 32'h10;
      vecs[4] = '{len: 4'd3, n: 3, s: '0, flush_last: 1'b0, esum: 40'h02_FFFF_FFFD, ecnt: 5'd3, ewide: 1'b1};
      for (int i = 0; i < 3; i++) vecs[4].s[i] = 32'hFFFF_FFFF;
      vecs[5] = '{len: 4'd4, n: 4, s: '0, flush_last: 1'b0, esum: 40'd4, ecnt: 5'd4, ewide: 1'b0};
      for (int i = 0; i < 4; i++) vecs[5].s[i] = 32'd1;

      reset     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h77;
      len       = 4'd0;
      flush     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_sum", 64'(out_sum), 64'(0));
      chk("rst_out_count", 64'(out_count), 64'(0));
      chk("rst_out_wide", 64'(out_wide), 64'(0));
      reset    = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("rst_nothing_accepted", 64'(out_count), 64'(0));

      for (int k = 0; k < 5; k++) run_block(k);

      // Flush with an empty block must not produce a result.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_empty_out_valid0", 64'(out_valid), 64'(0));
      tick();
      chk("flush_empty_out_valid1", 64'(out_valid), 64'(0));
      chk("flush_empty_count", 64'(out_count), 64'(0));

      // Backpressure: result must hold while inputs are ignored.
      out_ready = 1'b0;
      len       = 4'd1;
      in_valid  = 1'b1;
      in_data   = 32'h55;
      m_e.sum = 40'h55; m_e.cnt = 5'd1; m_e.wide = 1'b0;
      q.push_back(m_e);
      tick();
      chk("bp_first_valid", 64'(out_valid), 64'(1));
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_data  = $urandom;
         tick();
         chk("bp_out_valid", 64'(out_valid), 64'(1));
         chk("bp_out_sum", 64'(out_sum), 64'h55);
         chk("bp_out_count", 64'(out_count), 64'(1));
         chk("bp_in_ready", 64'(in_ready), 64'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release", 64'(out_valid), 64'(0));

      // Reset part-way through a block discards it.
      len      = 4'd4;
      in_valid = 1'b1;
      in_data  = 32'd7;
      tick();
      tick();
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_count", 64'(out_count), 64'(0));
      chk("midrst_sum", 64'(out_sum), 64'(0));
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      run_block(5);

      tick();
      tick();
      chk("scoreboard_drained", 64'(q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
